// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared (38,32) Hamming layout: widths, parity/data positions, coverage masks
// Encoder and decoder both import this so the codeword layout lives in one place.
package hamming_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PAR_W  = 6;
  localparam int unsigned CODE_W = DATA_W + PAR_W;

  // Positions are 1-based; codeword bit (pos-1) holds position pos.
  localparam int unsigned PARITY_POS [PAR_W] = '{1, 2, 4, 8, 16, 32};

  localparam int unsigned DATA_POS [DATA_W] = '{
     3,  5,  6,  7,  9, 10, 11, 12, 13, 14, 15,
    17, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27, 28, 29, 30, 31,
    33, 34, 35, 36, 37, 38
  };

  // Codeword bits whose position index has bit k set.
  function automatic logic [CODE_W-1:0] cover_mask(input int unsigned k);
    logic [CODE_W-1:0] m;
    m = '0;
    for (int unsigned p = 1; p <= CODE_W; p++) begin
      m[p-1] = p[k];
    end
    return m;
  endfunction

  // XOR of the positions of all set bits; zero for a clean codeword,
  // the flipped position for a single-bit error.
  function automatic logic [PAR_W-1:0] syndrome(input logic [CODE_W-1:0] code);
    logic [PAR_W-1:0] s;
    s = '0;
    for (int unsigned p = 1; p <= CODE_W; p++) begin
      if (code[p-1]) s = s ^ PAR_W'(p);
    end
    return s;
  endfunction

endpackage

// File: rtl/hamming_parity_gen.sv
// rtl/hamming_parity_gen.sv - combinational data placement and even-parity generation
// Produces the unregistered 38-bit codeword for a 32-bit data word.
module hamming_parity_gen
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [CODE_W-1:0] codeword
);

  logic [CODE_W-1:0] placed;

  always_comb begin
    placed = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      placed[DATA_POS[i]-1] = data[i];
    end
    // Parity positions are zero in placed, so masking it never folds parity into parity.
    codeword = placed;
    for (int unsigned k = 0; k < PAR_W; k++) begin
      codeword[PARITY_POS[k]-1] = ^(placed & cover_mask(k));
    end
  end

endmodule

// File: rtl/hamming_encoder_38_32.sv
// rtl/hamming_encoder_38_32.sv - registered (38,32) SEC encoder, 1-cycle latency
// HAMMING_SECDED_EN adds registered overall parity output parity_all for SECDED (39,32).
module hamming_encoder_38_32
  import hamming_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  output logic [CODE_W-1:0] data_out
`ifdef HAMMING_SECDED_EN
  ,
  output logic              parity_all
`endif
);

  logic [CODE_W-1:0] code_next;

  hamming_parity_gen u_parity_gen (
    .data     (data_in),
    .codeword (code_next)
  );

  // Load only on in_valid so idle-cycle data_in never reaches the register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      data_out  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) data_out <= code_next;
    end
  end

`ifdef HAMMING_SECDED_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_all <= 1'b0;
    end else if (in_valid) begin
      parity_all <= ^code_next;
    end
  end
`endif

endmodule

// File: tb/tb_hamming_encoder_38_32.sv
// tb/tb_hamming_encoder_38_32.sv - scoreboard bench for hamming_encoder_38_32
// Define HAMMING_SECDED_EN to also check parity_all.
module tb_hamming_encoder_38_32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] data_in;
  logic        out_valid;
  logic [37:0] data_out;
`ifdef HAMMING_SECDED_EN
  logic        parity_all;
`endif

  always #5 clk = ~clk;

  hamming_encoder_38_32 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .out_valid (out_valid),
    .data_out  (data_out)
`ifdef HAMMING_SECDED_EN
    ,
    .parity_all(parity_all)
`endif
  );

  typedef struct {
    logic [37:0] code;
    logic        pall;
    int          issue;
    logic        is_cafe;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [37:0] cafe_code = '0;
  logic        cafe_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0] ref_syndrome(input logic [37:0] c);
    logic [5:0] s;
    s = '0;
    for (int i = 0; i < 38; i++) begin
      if (c[i]) s = s ^ 6'(i + 1);
    end
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [37:0] code,
                       input logic pall, input logic cafe);
    exp_t e;
    in_valid = v;
    data_in  = d;
    if (v && !rst) begin
      e.code = code; e.pall = pall; e.issue = cyc; e.is_cafe = cafe;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every out_valid pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", 64'(out_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        check("codeword", 64'(data_out), 64'(e.code));
        check("latency", 64'(cyc), 64'(e.issue + 1));
        check("syndrome", 64'(ref_syndrome(data_out)), 64'd0);
`ifdef HAMMING_SECDED_EN
        check("parity_all", 64'(parity_all), 64'(e.pall));
`endif
        if (e.is_cafe) begin
          cafe_code = data_out;
          cafe_seen = 1'b1;
        end
      end
    end
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    data_in  = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_data_out", 64'(data_out), 64'd0);
`ifdef HAMMING_SECDED_EN
    check("reset_parity_all", 64'(parity_all), 64'd0);
`endif
    rst = 1'b0;

    drive(1'b1, 32'h0000_0000, 38'h00_0000_0000, 1'b0, 1'b0);
    drive(1'b1, 32'h0000_0001, 38'h00_0000_0007, 1'b1, 1'b0);
    drive(1'b1, 32'h8000_0000, 38'h20_8000_000A, 1'b0, 1'b0);
    drive(1'b1, 32'hFFFF_FFFF, 38'h3F_7FFF_FFF4, 1'b0, 1'b0);

    drive(1'b1, 32'h0000_0001, 38'h00_0000_0007, 1'b1, 1'b0);
    drive(1'b1, 32'h8000_0000, 38'h20_8000_000A, 1'b0, 1'b0);
    drive(1'b1, 32'hCAFE_3475, 38'h32_DFC6_47A7, 1'b1, 1'b1);

    // Idle with junk on data_in: output must hold the last codeword.
    drive(1'b0, 32'h1234_5678, 38'h0, 1'b0, 1'b0);
    check("idle_out_valid", 64'(out_valid), 64'd0);
    check("idle_hold", 64'(data_out), 64'h32_DFC6_47A7);
    drive(1'b0, 32'hFFFF_0000, 38'h0, 1'b0, 1'b0);
    check("idle_hold2", 64'(data_out), 64'h32_DFC6_47A7);
`ifdef HAMMING_SECDED_EN
    check("idle_parity_hold", 64'(parity_all), 64'd1);
`endif

    if (!cafe_seen) begin
      check("cafe_captured", 64'd0, 64'd1);
    end else begin
      for (int i = 0; i < 38; i++) begin
        check("single_error_syndrome", 64'(ref_syndrome(cafe_code ^ (38'd1 << i))), 64'(i + 1));
      end
    end

    // Reset mid-stream: the word presented under reset is dropped.
    drive(1'b1, 32'hFFFF_FFFF, 38'h3F_7FFF_FFF4, 1'b0, 1'b0);
    rst      = 1'b1;
    in_valid = 1'b1;
    data_in  = 32'hCAFE_3475;
    @(posedge clk);
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_data_out", 64'(data_out), 64'd0);
    rst = 1'b0;
    drive(1'b1, 32'h8000_0000, 38'h20_8000_000A, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 38'h0, 1'b0, 1'b0);
    check("final_idle_out_valid", 64'(out_valid), 64'd0);

    for (int t = 0; t < 10 && sb.size() != 0; t++) @(posedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hamming_encoder_38_32.md
Name: hamming_encoder_38_32

Overview:
- Registered Hamming single-error-correcting (SEC) encoder.
- Maps a 32-bit data word to a 38-bit codeword: 32 data bits plus 6 even-parity bits.
- Sits at the write side of a protected storage or link datapath. The matching decoder is a separate block.

Parameters:
- None. Widths are fixed by package constants: DATA_W=32, PAR_W=6, CODE_W=38.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  data_in is valid this cycle
- data_in  input  32  data word to encode
- out_valid  output  1  data_out holds a valid codeword
- data_out  output  38  registered codeword
- parity_all  output  1  overall parity; present only when HAMMING_SECDED_EN is defined

Behaviour:
- Codeword positions are numbered 1..38, and data_out[i-1] holds position i.
- Parity positions are 1, 2, 4, 8, 16, 32, i.e. data_out bits 0, 1, 3, 7, 15, 31.
- Data placement: data_in[0] goes to the lowest non-power-of-two position, then ascending.
  - d0 at position 3; d1–d3 at positions 5–7; d4–d10 at 9–15; d11–d25 at 17–31; d26–d31 at 33–38.
- Parity bit at position 2^k is the XOR of all data positions whose index has bit k set (even parity).
- The parity generator is purely combinational. The codeword and valid are registered.
- Latency is 1 clock:
  - A cycle with in_valid=1 at edge N gives data_out = enc(data_in) and out_valid=1 after edge N.
  - A cycle with in_valid=0 gives out_valid=0 at the next edge; data_out holds its last value.
- No backpressure. One word is accepted every cycle in_valid=1, and back-to-back words produce back-to-back outputs.
- Reset is synchronous and active-high:
  - At the first edge with rst=1: data_out=0, out_valid=0, parity_all=0.
  - rst has priority over in_valid; a word presented during reset is dropped.
  - Deasserting reset mid-stream resumes on the next in_valid.
- X or uninitialised data_in while in_valid=0 must not affect data_out.

Optional Feature:
- Macro HAMMING_SECDED_EN.
- Defined:
  - Adds output parity_all = XOR of all 38 bits of the registered codeword, registered in the same cycle as data_out.
  - Together with data_out this forms a SECDED (39,32) code.
  - Reset value is 0.
- Undefined: the port and its logic are absent; behaviour is pure SEC (38,32).

Decomposition:
- Package hamming_pkg holds:
  - DATA_W, PAR_W, CODE_W;
  - a constant array of the six parity positions;
  - a function or constant table mapping data index to codeword position, so the decoder shares the same layout.
- One sub-module, hamming_parity_gen: combinational, 32-bit data in, 38-bit unregistered codeword out.
- The top level adds the register stage, the valid pipeline and the optional parity_all.

Test Plan:
- Reset: assert rst with in_valid=1, data_in=0xFFFFFFFF -> data_out=0, out_valid=0 (and parity_all=0) after the edge.
- Single-bit data: data_in=0x00000000 -> 38'h0; data_in=0x00000001 -> 38'h0000000007 (parity_all=1).
- MSB: data_in=0x80000000 -> 38'h208000000A (parity_all=0).
- All ones: data_in=0xFFFFFFFF -> 38'h3F7FFFFFF4 (parity_all=0).
- Streaming:
  - Drive 0x00000001, 0x80000000, 0xCAFE3475 on consecutive cycles with in_valid=1 -> three consecutive out_valid=1 cycles, in order, 1-cycle latency.
  - Each codeword's recomputed syndrome = 0.
  - Then in_valid=0 -> out_valid=0, data_out held.
- Single-error property: for the codeword of 0xCAFE3475, flip each of bits 0..37 in turn -> the recomputed syndrome equals that bit's position (1..38) every time.
